// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the ECC scrub controller and its Hamming(12,8) syndrome unit.
package ecc_scrub_pkg;
    localparam int CW_W    = 12;
    localparam int SYN_W   = 4;
    localparam int MAX_POS = 12;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EVAL,
        WR,
        DONE
    } state_t;
endpackage

// File: rtl/hamming_syn12.sv
// Combinational Hamming(12,8) syndrome and single-bit correction.
// Codeword position p (1..12) lives at bit CW_W-p, so position 1 is the MSB.
module hamming_syn12
    import ecc_scrub_pkg::*;
(
    input  logic [CW_W-1:0]  codeword_i,
    output logic [SYN_W-1:0] syndrome_o,
    output logic [CW_W-1:0]  corrected_o,
    output logic             correctable_o,
    output logic             uncorrectable_o
);
    localparam logic [CW_W-1:0] POS1_MASK = {1'b1, {(CW_W-1){1'b0}}};

    logic [SYN_W-1:0] syn;

    always_comb begin
        syn = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (codeword_i[CW_W-p]) syn = syn ^ SYN_W'(p);
        end
    end

    assign syndrome_o      = syn;
    assign correctable_o   = (syn != '0) && (syn <= SYN_W'(MAX_POS));
    assign uncorrectable_o = (syn > SYN_W'(MAX_POS));
    assign corrected_o     = correctable_o ? (codeword_i ^ (POS1_MASK >> (syn - 1'b1))) : codeword_i;
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: reads each codeword, rewrites single-bit errors, counts corrections.
// Define ECC_SCRUB_LOG_EN to expose the address and syndrome of the most recent bad word.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [CW_W-1:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [CW_W-1:0]   mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`ifdef ECC_SCRUB_LOG_EN
    ,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic [SYN_W-1:0]  last_err_syn
`endif
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  uncorr_q, uncorr_d;
    logic [CW_W-1:0]   wdata_q, wdata_d;

    logic [SYN_W-1:0]  syn;
    logic [CW_W-1:0]   fixed;
    logic              can_fix, cant_fix;
    logic              last;

    hamming_syn12 u_syn (
        .codeword_i      (mem_rd_data),
        .syndrome_o      (syn),
        .corrected_o     (fixed),
        .correctable_o   (can_fix),
        .uncorrectable_o (cant_fix)
    );

    assign last = (addr_q == ADDR_W'(DEPTH - 1));

`ifdef ECC_SCRUB_LOG_EN
    logic [ADDR_W-1:0] log_addr_q, log_addr_d;
    logic [SYN_W-1:0]  log_syn_q, log_syn_d;
`else
    logic unused_syn;
    assign unused_syn = ^syn;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        wdata_d  = wdata_q;
`ifdef ECC_SCRUB_LOG_EN
        log_addr_d = log_addr_q;
        log_syn_d  = log_syn_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    corr_d   = '0;
                    uncorr_d = '0;
                    addr_d   = '0;
                    state_d  = RD;
`ifdef ECC_SCRUB_LOG_EN
                    log_addr_d = '0;
                    log_syn_d  = '0;
`endif
                end
            end
            RD: state_d = EVAL;
            EVAL: begin
`ifdef ECC_SCRUB_LOG_EN
                if (syn != '0) begin
                    log_addr_d = addr_q;
                    log_syn_d  = syn;
                end
`endif
                if (cant_fix && uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
                if (can_fix) begin
                    wdata_d = fixed;
                    state_d = WR;
                end else if (last || stop) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD;
                end
            end
            WR: begin
                if (corr_q != '1) corr_d = corr_q + 1'b1;
                // A write in flight always lands before stop is honoured.
                if (last || stop) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
            wdata_q  <= '0;
`ifdef ECC_SCRUB_LOG_EN
            log_addr_q <= '0;
            log_syn_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            wdata_q  <= wdata_d;
`ifdef ECC_SCRUB_LOG_EN
            log_addr_q <= log_addr_d;
            log_syn_q  <= log_syn_d;
`endif
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd_en   = (state_q == RD);
    assign mem_wr_en   = (state_q == WR);
    assign mem_wr_data = mem_wr_en ? wdata_q : '0;
    assign busy        = (state_q == RD) || (state_q == EVAL) || (state_q == WR);
    assign done        = (state_q == DONE);
    assign corr_cnt    = corr_q;
    assign uncorr_cnt  = uncorr_q;
`ifdef ECC_SCRUB_LOG_EN
    assign last_err_addr = log_addr_q;
    assign last_err_syn  = log_syn_q;
`endif
endmodule
